pcpi_seq_mul: RTL and testbench
===============================

# pcpi_seq_mul

Sequential RV32M multiplier on the PCPI bus. It decodes MUL, MULH, MULHSU and MULHU from `pcpi_insn` and computes the 64-bit product with a shift-add datapath, STEPS bits per cycle. It returns the selected 32-bit half on the internal PCPI response signals. It sits directly upstream of the PCPI interface mux and drives the mux's internal-coprocessor response inputs (ready/wait/rd/wr).

## Interface
- STEPS, 1, product bits retired per cycle; legal values 1, 2, 4, 8; N = 64/STEPS.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- pcpi_valid  in  1  core request, held until `pcpi_ready` or withdrawn.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand A.
- pcpi_rs2  in  32  operand B.
- pcpi_wr  out  1  write-back request; equals `pcpi_ready`.
- pcpi_rd  out  32  result; 0 except in DONE.
- pcpi_wait  out  1  busy, asks the core to extend its timeout.
- pcpi_ready  out  1  one-cycle completion pulse.

## Operation
- Match condition:
  - insn[6:0]=0110011, insn[31:25]=0000001, insn[14:12]∈{000,001,010,011}.
  - Other funct3 values (DIV/REM) and all other encodings never start the block.
- Operands are extended to 64 bits:
  - rs1 is signed for MULH and MULHSU, unsigned otherwise.
  - rs2 is signed for MULH only.
- Product = extA × extB mod 2^64, computed by shift-add with a 64-bit accumulator.
- Result selection: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN when `pcpi_valid` & match & !guard. On this transition, latch the extended operands and result select, and clear the counter and accumulator.
  - RUN: each cycle adds STEPS partial products and advances the counter by STEPS.
    - RUN → DONE after N RUN cycles.
    - RUN → IDLE (abort) if `pcpi_valid` is sampled low. No `pcpi_ready`; the partial result is discarded.
  - DONE: `pcpi_ready`=`pcpi_wr`=1, `pcpi_rd`=result. Next state is IDLE unconditionally.
- guard is a register set in DONE and cleared otherwise. It blocks restart in the cycle after DONE even if `pcpi_valid` is still high.
- All outputs are registered; none depend combinationally on inputs.

## Timing
- Reset values: `pcpi_wr`=0, `pcpi_rd`=0, `pcpi_wait`=0, `pcpi_ready`=0; FSM=IDLE; guard=0.
- A match is sampled at edge 0. `pcpi_wait`=1 during cycles 1..N. `pcpi_ready` pulses in cycle N+1.
- Latency from the start edge to `pcpi_ready` is N+1 cycles: 65 for STEPS=1, 9 for STEPS=8.
- `pcpi_wait` and `pcpi_ready` are never high in the same cycle.
- On abort, `pcpi_wait` falls in the cycle after `pcpi_valid` is sampled low.
- The earliest new start is 2 cycles after DONE: guard cycle, then IDLE sample.
- Reset asserted mid-RUN or in DONE: outputs go to 0 immediately (asynchronous). The operation is lost and `pcpi_ready` never follows.
- Operands and insn are sampled only at the start edge. Later changes to them are ignored.

## Configuration
- `PCPI_SEQ_MUL_ZERO_FASTPATH_EN`
  - Defined: if either latched 64-bit operand is 0 at the start edge, the FSM goes IDLE → DONE with result 0. `pcpi_ready` arrives in cycle 1 and `pcpi_wait` is never asserted.
  - Undefined: zero operands take the full N+1 cycles like any other operand.

## Test plan
- MUL, STEPS=1: insn 0x02B50533, rs1=7, rs2=6 → `pcpi_wait` high for cycles 1..64; `pcpi_ready`=`pcpi_wr`=1 with `pcpi_rd`=0x0000002A in cycle 65.
- MULH vs MULHU, STEPS=4: rs1=rs2=0xFFFFFFFF.
  - insn 0x02B51533 → `pcpi_rd`=0x00000000.
  - insn 0x02B53533 → `pcpi_rd`=0xFFFFFFFE.
  - Ready in cycle 17.
- MULHSU, STEPS=8: insn 0x02B52533, rs1=0xFFFFFFFF, rs2=2 → `pcpi_rd`=0xFFFFFFFF in cycle 9.
- Non-match: insn 0x02B54533 (DIV) held valid for 100 cycles → `pcpi_wait`, `pcpi_ready` and `pcpi_rd` stay 0.
- Abort and guard, STEPS=1:
  - Drop `pcpi_valid` at cycle 10 → `pcpi_wait`=0 from cycle 11 and no `pcpi_ready`.
  - A restarted MUL 3×5 returns 15.
  - Holding `pcpi_valid` high through DONE → no restart in the guard cycle.
- Reset: assert `reset` at cycle 30 of a run → all outputs 0 the same cycle. After release, a MUL 0x10000×0x10000 returns 0x00000000, and MULHU returns 0x00000001.

Source files
------------

// File: rtl/pcpi_seq_mul.sv
// pcpi_seq_mul: sequential RV32M multiplier (MUL, MULH, MULHSU, MULHU) on the
// PCPI bus. A shift-add datapath with a 64-bit accumulator retires STEPS
// product bits per cycle. All outputs come straight from registers.
//
// Build option: PCPI_SEQ_MUL_ZERO_FASTPATH_EN
//   defined   - a zero operand goes straight from IDLE to DONE with result 0
//   undefined - every operation takes the full 64/STEPS + 1 cycles
//
// state | meaning
// IDLE  | waiting for a matching request, no outputs asserted
// RUN   | shift-add in progress, pcpi_wait high
// DONE  | result on pcpi_rd, one-cycle pcpi_ready / pcpi_wr pulse
module pcpi_seq_mul #(
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  // Counter value during the final RUN cycle; the counter advances by STEPS.
  localparam logic [6:0] LAST_CNT = 7'(64 - STEPS);
  localparam logic [6:0] CNT_STEP = 7'(STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_guard;
  logic        r_hi;
  logic [6:0]  r_cnt;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [63:0] r_acc;
  logic        r_wait;
  logic        r_ready;
  logic [31:0] r_rd;

  logic [2:0]  w_funct3;
  logic        w_match;
  logic        w_sign_a;
  logic        w_sign_b;
  logic        w_start;
  logic        w_fast;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_acc_nxt;
  logic        w_unused_insn;

  // Decode: only funct3 000..011 of the M-extension OP encoding are ours;
  // DIV/REM (funct3[2]=1) are left for another coprocessor.
  assign w_funct3 = pcpi_insn[14:12];
  assign w_match  = (pcpi_insn[6:0] == 7'b0110011) &&
                    (pcpi_insn[31:25] == 7'b0000001) &&
                    !w_funct3[2];
  assign w_sign_a = (w_funct3[1:0] == 2'b01) || (w_funct3[1:0] == 2'b10);
  assign w_sign_b = (w_funct3[1:0] == 2'b01);
  assign w_ext_a  = {{32{w_sign_a & pcpi_rs1[31]}}, pcpi_rs1};
  assign w_ext_b  = {{32{w_sign_b & pcpi_rs2[31]}}, pcpi_rs2};
  // The guard stops a still-high pcpi_valid from relaunching the same op.
  assign w_start  = pcpi_valid && w_match && !r_guard;

  // Register fields and rs numbers play no part in the computation.
  assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

`ifdef PCPI_SEQ_MUL_ZERO_FASTPATH_EN
  assign w_fast = (w_ext_a == 64'd0) || (w_ext_b == 64'd0);
`else
  assign w_fast = 1'b0;
`endif

  // Add STEPS partial products: bit i of the multiplier selects A << i.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < STEPS; i++) begin
      if (r_b[i]) begin
        w_acc_nxt = w_acc_nxt + (r_a << i);
      end
    end
  end

  // Sequencer and datapath registers, including the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_guard <= 1'b0;
      r_hi    <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_wait  <= 1'b0;
      r_ready <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_guard <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a   <= w_ext_a;
            r_b   <= w_ext_b;
            r_acc <= '0;
            r_cnt <= '0;
            r_hi  <= (w_funct3 != 3'b000);
            if (w_fast) begin
              r_state <= S_DONE;
              r_ready <= 1'b1;
              r_rd    <= '0;
            end else begin
              r_state <= S_RUN;
              r_wait  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!pcpi_valid) begin
            // Core withdrew the request: drop the partial product silently.
            r_state <= S_IDLE;
            r_wait  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << STEPS;
            r_b   <= r_b >> STEPS;
            r_cnt <= r_cnt + CNT_STEP;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_DONE;
              r_wait  <= 1'b0;
              r_ready <= 1'b1;
              r_rd    <= r_hi ? w_acc_nxt[63:32] : w_acc_nxt[31:0];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rd    <= '0;
          r_guard <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_wait  <= 1'b0;
          r_ready <= 1'b0;
          r_rd    <= '0;
        end
      endcase
    end
  end

  assign pcpi_wait  = r_wait;
  assign pcpi_ready = r_ready;
  assign pcpi_wr    = r_ready;
  assign pcpi_rd    = r_rd;

endmodule

// File: tb/tb_pcpi_seq_mul.sv
// Testbench for pcpi_seq_mul: directed sequence with a result scoreboard.
module tb_pcpi_seq_mul;

  localparam int STEPS = 4;
  localparam int N     = 64 / STEPS;
`ifdef PCPI_SEQ_MUL_ZERO_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  localparam logic [31:0] I_MUL    = 32'h02B50533;
  localparam logic [31:0] I_MULH   = 32'h02B51533;
  localparam logic [31:0] I_MULHSU = 32'h02B52533;
  localparam logic [31:0] I_MULHU  = 32'h02B53533;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  always #5 clk = ~clk;

  pcpi_seq_mul #(.STEPS(STEPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product from a plain 64-bit multiply of the extended operands.
  function automatic logic [31:0] ref_mul(input logic [31:0] insn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [2:0]  f3;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    f3 = insn[14:12];
    ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
  endtask

  task automatic req(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    sb_q.push_back(ref_mul(insn, a, b));
    drive(insn, a, b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with the request already driven: the next posedge is
  // the start edge. Returns at the negedge of the ready cycle.
  task automatic collect(input string tag, input bit keep_valid, input bit zero_op);
    int          cyc;
    int          waits;
    int          exp_lat;
    bit          seen;
    bit          rd_leak;
    logic [31:0] exp;
    exp_lat = (FASTPATH && zero_op) ? 1 : N + 1;
    cyc = 0;
    waits = 0;
    seen = 1'b0;
    rd_leak = 1'b0;
    @(posedge clk);
    while (!seen && cyc < 4 * N + 20) begin
      @(negedge clk);
      cyc++;
      if (pcpi_ready === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (pcpi_wait === 1'b1) waits++;
        if (pcpi_rd !== 32'd0) rd_leak = 1'b1;
      end
    end
    chk({tag, " ready_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " wait_cycles"}, 64'(waits), 64'(exp_lat - 1));
    chk({tag, " rd_zero_while_busy"}, 64'(rd_leak), 64'd0);
    if (seen) begin
      chk({tag, " wait_low_at_ready"}, 64'(pcpi_wait), 64'd0);
      chk({tag, " wr"}, 64'(pcpi_wr), 64'd1);
      chk({tag, " scoreboard_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        chk({tag, " rd"}, 64'(pcpi_rd), 64'(exp));
      end
    end
    if (!keep_valid) pcpi_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t         ops[$];
    logic [31:0] nm_insn[4];
    logic [31:0] ra;
    logic [31:0] rb;
    bit          flag;
    int          cyc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(pcpi_ready), 64'd0);
    chk("reset wait", 64'(pcpi_wait), 64'd0);
    chk("reset wr", 64'(pcpi_wr), 64'd0);
    chk("reset rd", 64'(pcpi_rd), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed products, including sign-extension corner cases
    ops.push_back('{I_MUL,    32'd7,        32'd6});
    ops.push_back('{I_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF});
    ops.push_back('{I_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF});
    ops.push_back('{I_MULHSU, 32'hFFFFFFFF, 32'd2});
    ops.push_back('{I_MULH,   32'h80000000, 32'h80000000});
    ops.push_back('{I_MULHSU, 32'h80000000, 32'hFFFFFFFF});
    ops.push_back('{I_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF});
    ops.push_back('{I_MULHU,  32'h7FFFFFFF, 32'h80000001});
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      ops.push_back('{{7'b0000001, 5'd11, 5'd10, 3'(i % 4), 5'd10, 7'b0110011}, ra, rb});
    end
    foreach (ops[k]) begin
      req(ops[k].insn, ops[k].a, ops[k].b);
      collect($sformatf("op%0d", k), 1'b0, 1'b0);
      idle(3);
    end

    // Zero operands take the normal path in the default build
    req(I_MUL, 32'd0, 32'd5);
    collect("zero_rs1", 1'b0, 1'b1);
    idle(3);
    req(I_MULHU, 32'd12345, 32'd0);
    collect("zero_rs2", 1'b0, 1'b1);
    idle(3);

    // Non-matching encodings never start the block
    nm_insn[0] = 32'h02B54533;
    nm_insn[1] = 32'h02B57533;
    nm_insn[2] = 32'h00B50533;
    nm_insn[3] = 32'h02B50513;
    for (int k = 0; k < 4; k++) begin
      drive(nm_insn[k], 32'd9, 32'd9);
      flag = 1'b0;
      repeat (25) begin
        @(negedge clk);
        if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_rd !== 32'd0) flag = 1'b1;
      end
      chk($sformatf("nonmatch %h quiet", nm_insn[k]), 64'(flag), 64'd0);
    end
    pcpi_valid = 1'b0;
    idle(2);

    // Abort: drop valid in cycle 10
    drive(I_MUL, 32'd9, 32'd9);
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("abort wait_before_drop", 64'(pcpi_wait), 64'd1);
    pcpi_valid = 1'b0;
    @(negedge clk);
    chk("abort wait_falls", 64'(pcpi_wait), 64'd0);
    flag = 1'b0;
    repeat (N + 5) begin
      @(negedge clk);
      if (pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0) flag = 1'b1;
    end
    chk("abort no_ready", 64'(flag), 64'd0);
    req(I_MUL, 32'd3, 32'd5);
    collect("restart_3x5", 1'b0, 1'b0);
    idle(3);

    // Guard: valid held high through DONE
    req(I_MUL, 32'd11, 32'd13);
    collect("guard_first", 1'b1, 1'b0);
    @(negedge clk);
    chk("guard after_done wait", 64'(pcpi_wait), 64'd0);
    chk("guard after_done ready", 64'(pcpi_ready), 64'd0);
    @(negedge clk);
    chk("guard blocks_restart", 64'(pcpi_wait), 64'd0);
    sb_q.push_back(ref_mul(I_MUL, 32'd11, 32'd13));
    collect("guard_restart", 1'b0, 1'b0);
    idle(3);

    // Reset mid-RUN
    drive(I_MUL, 32'h1234, 32'h5678);
    @(posedge clk);
    repeat (N / 2) @(negedge clk);
    chk("rst_run wait_before", 64'(pcpi_wait), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_run wait", 64'(pcpi_wait), 64'd0);
    chk("rst_run ready", 64'(pcpi_ready), 64'd0);
    chk("rst_run rd", 64'(pcpi_rd), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pcpi_valid = 1'b0;
    flag = 1'b0;
    repeat (N + 5) begin
      @(negedge clk);
      if (pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0) flag = 1'b1;
    end
    chk("rst_run no_ready", 64'(flag), 64'd0);

    // Reset in DONE
    drive(I_MUL, 32'd100, 32'd200);
    @(posedge clk);
    cyc = 0;
    flag = 1'b0;
    while (!flag && cyc < 4 * N + 20) begin
      @(negedge clk);
      cyc++;
      if (pcpi_ready === 1'b1) flag = 1'b1;
    end
    chk("rst_done reached_done", 64'(flag), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_done ready", 64'(pcpi_ready), 64'd0);
    chk("rst_done wr", 64'(pcpi_wr), 64'd0);
    chk("rst_done rd", 64'(pcpi_rd), 64'd0);
    @(negedge clk);
    pcpi_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Operation after reset release
    req(I_MUL, 32'h00010000, 32'h00010000);
    collect("post_rst mul", 1'b0, 1'b0);
    idle(3);
    req(I_MULHU, 32'h00010000, 32'h00010000);
    collect("post_rst mulhu", 1'b0, 1'b0);
    idle(3);

    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
